// File: rtl/imm_encoder_pkg.sv
// +----------------------------------------------------------------------+
// | imm_encoder_pkg                                                       |
// | Shared types and constants for the rotated-immediate encoder.        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package imm_encoder_pkg;

    localparam int NUM_ROT = 16;

    typedef enum logic [1:0] {
        MODE_PLAIN = 2'b00,
        MODE_NOT   = 2'b01,
        MODE_NEG   = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEARCH_PRI = 2'd1,
        SEARCH_ALT = 2'd2,
        DONE       = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/imm_encoder_rot_right.sv
// +----------------------------------------------------------------------+
// | rot_right                                                             |
// | Combinational rotate-right of a WIDTH-bit word by a variable amount. |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module rot_right #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         data,
    input  logic [$clog2(WIDTH)-1:0] amount,
    output logic [WIDTH-1:0]         result
);

    logic [2*WIDTH-1:0] w_double;
    logic [2*WIDTH-1:0] w_shifted;

    // Shifting a doubled copy avoids the WIDTH-bit shift corner case at amount 0.
    assign w_double  = {data, data};
    assign w_shifted = w_double >> amount;
    assign result    = w_shifted[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/imm_encoder.sv
// +----------------------------------------------------------------------+
// | imm_encoder                                                           |
// | Sequential search for an 8-bit/even-rotation immediate encoding.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] value,
    input  logic [1:0]  mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        found,
    output logic        alt,
    output logic [11:0] imm12
);

    localparam logic [3:0] c_last_rot = 4'(NUM_ROT - 1);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_value;
    logic [31:0] r_alt_op;
    logic        r_has_alt;
    logic [3:0]  r_rot;
    logic        r_found;
    logic        r_alt;
    logic [11:0] r_imm12;

    logic        w_accept;
    logic        w_searching;
    logic [31:0] w_operand;
    logic [4:0]  w_amount;
    logic [31:0] w_candidate;
    logic        w_hit;
    logic        w_last;

    assign w_accept    = in_valid && (r_state == IDLE);
    assign w_searching = (r_state == SEARCH_PRI) || (r_state == SEARCH_ALT);
    assign w_operand   = (r_state == SEARCH_ALT) ? r_alt_op : r_value;
    // rol by 2r expressed as ror by (32 - 2r) mod 32; 5-bit wrap does the mod.
    assign w_amount    = 5'd0 - {r_rot, 1'b0};
    assign w_hit       = (w_candidate[31:8] == 24'd0);
    assign w_last      = (r_rot == c_last_rot);

    rot_right #(
        .WIDTH (32)
    ) u_rot_right (
        .data   (w_operand),
        .amount (w_amount),
        .result (w_candidate)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SEARCH_PRI;
                end
            end
            SEARCH_PRI: begin
                if (w_hit) begin
                    w_state_nxt = DONE;
                end else if (w_last) begin
                    w_state_nxt = r_has_alt ? SEARCH_ALT : DONE;
                end
            end
            SEARCH_ALT: begin
                if (w_hit || w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        found     = r_found;
        alt       = r_alt;
        imm12     = r_imm12;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value   <= 32'd0;
            r_alt_op  <= 32'd0;
            r_has_alt <= 1'b0;
            r_rot     <= 4'd0;
            r_found   <= 1'b0;
            r_alt     <= 1'b0;
            r_imm12   <= 12'd0;
        end else if (w_accept) begin
            r_value   <= value;
            r_rot     <= 4'd0;
            r_found   <= 1'b0;
            r_alt     <= 1'b0;
            r_imm12   <= 12'd0;
            case (mode_e'(mode))
                MODE_NOT: begin
                    r_alt_op  <= ~value;
                    r_has_alt <= 1'b1;
                end
                MODE_NEG: begin
                    r_alt_op  <= 32'd0 - value;
                    r_has_alt <= 1'b1;
                end
                default: begin
                    r_alt_op  <= value;
                    r_has_alt <= 1'b0;
                end
            endcase
        end else if (w_searching) begin
            if (w_hit) begin
                r_found <= 1'b1;
                r_alt   <= (r_state == SEARCH_ALT);
                r_imm12 <= {r_rot, w_candidate[7:0]};
            end else if (!w_last) begin
                r_rot <= r_rot + 4'd1;
            end else begin
                r_rot <= 4'd0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder.sv
// +----------------------------------------------------------------------+
// | tb_imm_encoder                                                        |
// | Self-checking bench: directed vectors plus randomized model compare. |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] value;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic        found;
    logic        alt;
    logic [11:0] imm12;

    int checks = 0;
    int errors = 0;

    imm_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .value     (value),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .found     (found),
        .alt       (alt),
        .imm12     (imm12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: try the primary operand, then the alternate, rotations in ascending order.
    function automatic void model(input logic [31:0] v, input logic [1:0] m,
                                  output logic f, output logic a,
                                  output logic [11:0] imm, output int lat);
        logic [31:0] ops [2];
        logic [31:0] c;
        logic [3:0]  r4;
        int          nops;
        ops[0] = v;
        ops[1] = v;
        nops   = 1;
        if (m == 2'b01) begin ops[1] = ~v;        nops = 2; end
        if (m == 2'b10) begin ops[1] = 32'd0 - v; nops = 2; end
        f = 1'b0; a = 1'b0; imm = 12'h000; lat = 0;
        for (int p = 0; p < nops; p++) begin
            for (int r = 0; r < 16; r++) begin
                lat++;
                if (r == 0) c = ops[p];
                else        c = (ops[p] << (2 * r)) | (ops[p] >> (32 - 2 * r));
                if (c < 32'd256) begin
                    r4  = r[3:0];
                    f   = 1'b1;
                    a   = (p == 1);
                    imm = {r4, c[7:0]};
                    return;
                end
            end
        end
    endfunction

    // Drives one request, scrambles the inputs during the search, and waits for out_valid.
    task automatic send(input logic [31:0] v, input logic [1:0] m, output int lat,
                        output logic f, output logic a, output logic [11:0] imm);
        @(negedge clk);
        in_valid = 1'b1;
        value    = v;
        mode     = m;
        @(posedge clk);
        #1;
        lat = -1;
        for (int e = 1; e <= 40; e++) begin
            in_valid = 1'($urandom);
            value    = $urandom;
            mode     = 2'($urandom);
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = e;
                break;
            end
        end
        in_valid = 1'b0;
        f   = found;
        a   = alt;
        imm = imm12;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, found, alt, imm12} !== {1'b1, 1'b1 ^ 1'b1, 1'b0, 1'b0, 12'h000}) begin
            errors++;
            $display("FAIL reset: rdy/ov/found/alt/imm=%b/%b/%b/%b/%h expected 1/0/0/0/000",
                     in_ready, out_valid, found, alt, imm12);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] vv [6];
        logic [1:0]  mm [6];
        logic        ef, ea, of, oa;
        logic [11:0] ei, oi;
        int          el, ol;
        logic [11:0] exp_imm [6];
        int          exp_lat [6];
        logic        exp_f [6];
        logic        exp_a [6];
        vv[0] = 32'h000000FF; mm[0] = 2'b00; exp_f[0] = 1; exp_a[0] = 0; exp_imm[0] = 12'h0FF; exp_lat[0] = 1;
        vv[1] = 32'hFF000000; mm[1] = 2'b00; exp_f[1] = 1; exp_a[1] = 0; exp_imm[1] = 12'h4FF; exp_lat[1] = 5;
        vv[2] = 32'h00000101; mm[2] = 2'b00; exp_f[2] = 0; exp_a[2] = 0; exp_imm[2] = 12'h000; exp_lat[2] = 16;
        vv[3] = 32'hFFFFFF00; mm[3] = 2'b01; exp_f[3] = 1; exp_a[3] = 1; exp_imm[3] = 12'h0FF; exp_lat[3] = 17;
        vv[4] = 32'hFFFFFFFF; mm[4] = 2'b10; exp_f[4] = 1; exp_a[4] = 1; exp_imm[4] = 12'h001; exp_lat[4] = 17;
        vv[5] = 32'hFFFFFFFF; mm[5] = 2'b11; exp_f[5] = 0; exp_a[5] = 0; exp_imm[5] = 12'h000; exp_lat[5] = 16;
        for (int i = 0; i < 6; i++) begin
            model(vv[i], mm[i], ef, ea, ei, el);
            send(vv[i], mm[i], ol, of, oa, oi);
            checks++;
            if ({of, oa, oi} !== {exp_f[i], exp_a[i], exp_imm[i]} || ol != exp_lat[i]) begin
                errors++;
                $display("FAIL directed[%0d]: got f=%b a=%b imm=%h lat=%0d expected f=%b a=%b imm=%h lat=%0d",
                         i, of, oa, oi, ol, exp_f[i], exp_a[i], exp_imm[i], exp_lat[i]);
            end
            checks++;
            if ({of, oa, oi} !== {ef, ea, ei} || ol != el) begin
                errors++;
                $display("FAIL directed_model[%0d]: got f=%b a=%b imm=%h lat=%0d model f=%b a=%b imm=%h lat=%0d",
                         i, of, oa, oi, ol, ef, ea, ei, el);
            end
            consume();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed_release[%0d]: out_valid=%b in_ready=%b expected 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_wrap_neg();
        logic        of, oa;
        logic [11:0] oi;
        int          ol;
        // 0x80000000 is encodable as-is (imm 0x02, rotation 1), so the primary wins.
        send(32'h80000000, 2'b10, ol, of, oa, oi);
        checks++;
        if ({of, oa, oi} !== {1'b1, 1'b0, 12'h102} || ol != 2) begin
            errors++;
            $display("FAIL wrap_neg: got f=%b a=%b imm=%h lat=%0d expected 1/0/102/2", of, oa, oi, ol);
        end
        consume();
    endtask

    task automatic test_random();
        logic [31:0] v, base;
        logic [1:0]  m;
        logic        ef, ea, of, oa;
        logic [11:0] ei, oi;
        int          el, ol, rr, kind;
        for (int i = 0; i < 60; i++) begin
            rr   = 2 * $urandom_range(0, 15);
            base = {24'd0, 8'($urandom)};
            if (rr != 0) base = (base >> rr) | (base << (32 - rr));
            kind = $urandom_range(0, 3);
            case (kind)
                0:       v = $urandom;
                1:       v = base;
                2:       v = ~base;
                default: v = 32'd0 - base;
            endcase
            m = 2'($urandom);
            model(v, m, ef, ea, ei, el);
            send(v, m, ol, of, oa, oi);
            checks++;
            if ({of, oa, oi} !== {ef, ea, ei} || ol != el) begin
                errors++;
                $display("FAIL random[%0d] v=%h m=%b: got f=%b a=%b imm=%h lat=%0d model f=%b a=%b imm=%h lat=%0d",
                         i, v, m, of, oa, oi, ol, ef, ea, ei, el);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic        of, oa;
        logic [11:0] oi;
        int          ol;
        send(32'hFF000000, 2'b00, ol, of, oa, oi);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, found, alt, imm12} !== {1'b1, 1'b0, 1'b1, 1'b0, 12'h4FF}) begin
                errors++;
                $display("FAIL hold[%0d]: ov/rdy/f/a/imm=%b/%b/%b/%b/%h expected 1/0/1/0/4ff",
                         c, out_valid, in_ready, found, alt, imm12);
            end
        end
        in_valid = 1'b0;
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_search();
        logic        of, oa;
        logic [11:0] oi;
        int          ol;
        @(negedge clk);
        in_valid = 1'b1;
        value    = 32'h00000101;
        mode     = 2'b01;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, found, alt, imm12, in_ready} !== {1'b0, 1'b0, 1'b0, 12'h000, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset: ov/f/a/imm/rdy=%b/%b/%b/%h/%b expected 0/0/0/000/1",
                     out_valid, found, alt, imm12, in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ol = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) ol++;
        end
        checks++;
        if (ol != 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abandoned: out_valid cycles=%0d in_ready=%b expected 0/1", ol, in_ready);
        end
        send(32'h00003FC0, 2'b00, ol, of, oa, oi);
        checks++;
        if ({of, oa, oi} !== {1'b1, 1'b0, 12'hDFF} || ol != 14) begin
            errors++;
            $display("FAIL post_reset: got f=%b a=%b imm=%h lat=%0d expected 1/0/dff/14", of, oa, oi, ol);
        end
        consume();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        value     = 32'd0;
        mode      = 2'b00;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_wrap_neg();
        test_backpressure();
        test_reset_mid_search();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL expose: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL expose: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL expose: in_valid  input  1  request valid.
REQ-004 SHALL expose: in_ready  output  1  high only in IDLE; request accepted on edge with in_valid & in_ready.
REQ-005 SHALL expose: value  input  32  constant to encode; sampled at acceptance.
REQ-006 SHALL expose: mode  input  2  00 plain, 01 plain then ~value, 10 plain then -value (two's complement), 11 treated as 00; sampled at acceptance.
REQ-007 SHALL expose: out_valid  output  1  result valid, held until out_ready.
REQ-008 SHALL expose: out_ready  input  1  consumer accepts result on edge with out_valid & out_ready.
REQ-009 SHALL expose: found  output  1  encoding exists.
REQ-010 SHALL expose: alt  output  1  encoding is of ~value or -value, not of value.
REQ-011 SHALL expose: imm12  output  12  {rot[3:0], imm8[7:0]}, such that ror({24'h0, imm8}, 2*rot) equals the encoded operand; 12'h000 when found=0.

Function
REQ-012 SHALL implement FSM states IDLE, SEARCH_PRI, SEARCH_ALT, DONE.
REQ-013 On acceptance SHALL register value, the alternate operand (~value or -value per mode), and clear rotation counter r (4 bit); next state SEARCH_PRI.
REQ-014 Each SEARCH cycle SHALL test one rotation: candidate = rol(operand, 2*r); hit when candidate[31:8]==0.
REQ-015 On hit SHALL register found=1, imm12={r, candidate[7:0]}, alt=(state==SEARCH_ALT), enter DONE, raise out_valid.
REQ-016 Smallest r SHALL win; primary operand SHALL always be preferred over alternate.
REQ-017 On miss with r<15 SHALL increment r, staying in same state.
REQ-018 On miss at r=15 in SEARCH_PRI: mode 01/10 -> SEARCH_ALT with r=0; mode 00/11 -> DONE with found=0, alt=0, imm12=0.
REQ-019 On miss at r=15 in SEARCH_ALT SHALL enter DONE with found=0, alt=0, imm12=0.
REQ-020 Latency: out_valid high (k+1) edges after acceptance edge, k = number of rotations tested minus 1; max 16 (plain) or 32 (alternate).
REQ-021 In DONE, found/alt/imm12 SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 out_valid & out_ready SHALL return FSM to IDLE and clear out_valid at that edge; no new request accepted on the same edge (in_ready low in DONE).
REQ-023 in_valid, value, mode SHALL be ignored outside IDLE.
REQ-024 -value for 32'h80000000 SHALL be 32'h80000000 (wrap, no saturation).

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, r=0, out_valid=0, found=0, alt=0, imm12=0; in_ready=1.
REQ-026 Reset mid-search or in DONE SHALL abandon the request with no result emitted.

Structure
REQ-027 Shared package SHALL hold the mode enum (MODE_PLAIN, MODE_NOT, MODE_NEG), FSM state enum, and NUM_ROT=16.
REQ-028 Rotation SHALL reuse the existing rot_right sub-module with amount (32 - 2*r) mod 32; no other sub-module.
REQ-029 Search datapath SHALL use one rotator only (one rotation per cycle), no parallel 16-way compare.

Verification
REQ-030 value 32'h000000FF, mode 00 -> found=1, alt=0, imm12=12'h0FF, out_valid 1 edge after acceptance.
REQ-031 value 32'hFF000000, mode 00 -> found=1, imm12=12'h4FF, out_valid 5 edges after acceptance.
REQ-032 value 32'h00000101, mode 00 -> found=0, imm12=12'h000, out_valid 16 edges after acceptance.
REQ-033 value 32'hFFFFFF00, mode 01 -> found=1, alt=1, imm12=12'h0FF, out_valid 17 edges after acceptance; value 32'hFFFFFFFF, mode 10 -> found=1, alt=1, imm12=12'h001.
REQ-034 Hold out_ready=0 for 3 cycles in DONE -> outputs unchanged, in_ready=0; then out_ready=1 -> IDLE next edge, in_ready=1.
REQ-035 rst_n low at r=7 of a search -> immediately out_valid=0, found=0, imm12=0, in_ready=1; next request after release encodes correctly.
